qcordic_rot: RTL and testbench

Iterative CORDIC rotation-mode engine for the FM radio datapath. It converts a Q10 phase angle and Q10 amplitude into an I/Q sample pair: (amplitude·cos θ, amplitude·sin θ). It is the inverse of the qarctan demod stage and serves as the modulator/test-source end of the I/Q↔phase interface. Its handshake matches qarctan: a one-deep request, busy until done.

---
 rtl/qcordic_rot_pkg.sv | 12 +
 rtl/qcordic_rot_if.sv | 12 +
 rtl/qcordic_rot.sv | 82 ++++++++
 tb/tb_qcordic_rot.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/qcordic_rot_pkg.sv
// qcordic_rot_pkg: shared constants, atan table and state type for the CORDIC rotator
package qcordic_rot_pkg;
  localparam int QUANT_BITS = 10;
  localparam logic signed [31:0] CORDIC_K  = 32'sh26E;
  localparam logic signed [31:0] PI_Q      = 32'shC90;
  localparam logic signed [31:0] HALF_PI_Q = 32'sh648;
  localparam logic signed [31:0] ATAN [11] = '{
    32'sd804, 32'sd475, 32'sd251, 32'sd127, 32'sd64, 32'sd32,
    32'sd16, 32'sd8, 32'sd4, 32'sd2, 32'sd1
  };
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
endpackage

// File: rtl/qcordic_rot_if.sv
// qcordic_rot_if: angle/amplitude request and I/Q result bundle
interface qcordic_rot_if;
  logic angle_valid;
  logic ready;
  logic signed [31:0] angle;
  logic signed [31:0] amplitude;
  logic signed [31:0] i_out;
  logic signed [31:0] q_out;
  logic out_valid;
  modport master(output angle_valid, angle, amplitude, input ready, i_out, q_out, out_valid);
  modport slave(input angle_valid, angle, amplitude, output ready, i_out, q_out, out_valid);
endinterface

// File: rtl/qcordic_rot.sv
// qcordic_rot: iterative CORDIC rotation turning a Q10 phase and amplitude into an I/Q pair
module qcordic_rot
  import qcordic_rot_pkg::*;
#(
  parameter int ITERATIONS = 11
) (
  input logic clk,
  input logic reset_n,
  qcordic_rot_if.slave bus
);
  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);
  state_t r_state;
  logic signed [31:0] r_x, r_y, r_z, r_i, r_q;
  logic [3:0] r_count;
  logic r_neg, r_ready, r_valid;
  logic signed [31:0] w_clamp, w_z0, w_x0, w_xs, w_ys, w_at, w_xn, w_yn, w_zn;
  logic signed [63:0] w_prod;
  logic w_neg, w_d;
  always_comb begin
    w_clamp = bus.angle > PI_Q ? PI_Q : bus.angle < -PI_Q ? -PI_Q : bus.angle;
    w_neg = w_clamp > HALF_PI_Q || w_clamp < -HALF_PI_Q;
    w_z0 = w_clamp > HALF_PI_Q ? w_clamp - PI_Q : w_clamp < -HALF_PI_Q ? w_clamp + PI_Q : w_clamp;
    w_prod = 64'(bus.amplitude) * 64'(CORDIC_K);
    w_x0 = 32'(w_prod >>> QUANT_BITS);
    w_xs = r_x >>> r_count;
    w_ys = r_y >>> r_count;
    w_at = ATAN[r_count];
    w_d = !r_z[31];
    w_xn = w_d ? r_x - w_ys : r_x + w_ys;
    w_yn = w_d ? r_y + w_xs : r_y - w_xs;
    w_zn = w_d ? r_z - w_at : r_z + w_at;
  end
  // Results are captured from the final micro-rotation so they are valid alongside the DONE pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_i <= '0;
      r_q <= '0;
      r_count <= '0;
      r_neg <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.angle_valid) begin
          r_x <= w_x0;
          r_y <= '0;
          r_z <= w_z0;
          r_neg <= w_neg;
          r_count <= '0;
          r_ready <= 1'b0;
          r_state <= ROTATE;
        end
        ROTATE: begin
          r_x <= w_xn;
          r_y <= w_yn;
          r_z <= w_zn;
          r_count <= r_count + 4'd1;
          if (r_count == LAST) begin
            r_i <= r_neg ? -w_xn : w_xn;
            r_q <= r_neg ? -w_yn : w_yn;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ready = r_ready;
  assign bus.out_valid = r_valid;
  assign bus.i_out = r_i;
  assign bus.q_out = r_q;
endmodule

// File: tb/tb_qcordic_rot.sv
// tb_qcordic_rot: directed and random checks of qcordic_rot against a trigonometric model
module tb_qcordic_rot;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  qcordic_rot_if bus();
  qcordic_rot #(.ITERATIONS(11)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {int ang; int amp;} req_t;
  req_t pend[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
    n_chk++;
    assert (((obs - exp) <= tol && (exp - obs) <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: got %0.2f expected %0.2f +/- %0.1f", tag, obs, exp, tol);
    end
  endtask
  function automatic real ref_theta(input int a);
    int c;
    c = a > 3216 ? 3216 : a < -3216 ? -3216 : a;
    return real'(c) / 1024.0;
  endfunction
  function automatic int rand_ang();
    return int'($urandom_range(0, 24576)) - 12288;
  endfunction
  function automatic int rand_amp();
    return int'($urandom_range(256, 2048));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int ang, input int amp, output int ri, output int rq, output int lat);
    int w;
    w = 0;
    while (!bus.ready && w < 40) begin
      tick();
      w++;
    end
    bus.angle = ang;
    bus.amplitude = amp;
    bus.angle_valid = 1'b1;
    tick();
    bus.angle_valid = 1'b0;
    bus.angle = rand_ang();
    bus.amplitude = rand_amp();
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    ri = bus.i_out;
    rq = bus.q_out;
  endtask
  task automatic expect_req(input string tag, input int ang, input int amp, input real tol);
    int ri, rq, lat;
    real th;
    run(ang, amp, ri, rq, lat);
    th = ref_theta(ang);
    chk({tag, "_lat"}, lat, 12);
    chk_near({tag, "_i"}, real'(ri), real'(amp) * $cos(th), tol);
    chk_near({tag, "_q"}, real'(rq), real'(amp) * $sin(th), tol);
  endtask
  task automatic check_pop();
    req_t r;
    chk("held_queue_nonempty", pend.size() > 0, 1);
    if (pend.size() > 0) begin
      r = pend.pop_front();
      chk_near("held_i", real'(bus.i_out), real'(r.amp) * $cos(ref_theta(r.ang)), 6.0 + real'(r.amp) / 256.0);
      chk_near("held_q", real'(bus.q_out), real'(r.amp) * $sin(ref_theta(r.ang)), 6.0 + real'(r.amp) / 256.0);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int pulses, last, ri, rq, lat, a, m;
    real diff;
    bus.angle_valid = 1'b0;
    bus.angle = '0;
    bus.amplitude = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_i", bus.i_out, 0);
    chk("rst_q", bus.q_out, 0);
    reset_n = 1'b1;
    expect_req("ang0", 0, 1024, 4.0);
    expect_req("ang_halfpi", 32'h648, 1024, 4.0);
    expect_req("ang_pi", 32'hC90, 1024, 4.0);
    expect_req("ang_m_qpi", -32'h324, 1024, 4.0);
    expect_req("ang_clamp_pos", 32'h2000, 1024, 4.0);
    expect_req("ang_clamp_neg", -32'h2000, 1024, 4.0);
    pulses = 0;
    last = -1;
    bus.angle_valid = 1'b1;
    bus.angle = rand_ang();
    bus.amplitude = rand_amp();
    for (int c = 0; c < 40; c++) begin
      if (bus.ready) pend.push_back('{int'(bus.angle), int'(bus.amplitude)});
      tick();
      if (bus.out_valid) begin
        pulses++;
        if (last >= 0) chk("held_spacing", c - last, 13);
        last = c;
        check_pop();
      end
      bus.angle = rand_ang();
      bus.amplitude = rand_amp();
    end
    bus.angle_valid = 1'b0;
    chk("held_pulses", pulses, 3);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.out_valid) check_pop();
    end
    chk("held_queue_empty", pend.size(), 0);
    bus.angle = 32'h200;
    bus.amplitude = 32'h400;
    bus.angle_valid = 1'b1;
    tick();
    bus.angle_valid = 1'b0;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_i", bus.i_out, 0);
    chk("midrst_q", bus.q_out, 0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    expect_req("after_rst", 32'h200, 1024, 4.0);
    for (int k = 0; k < 20; k++) begin
      a = rand_ang();
      m = rand_amp();
      expect_req("rand", a, m, 6.0 + real'(m) / 256.0);
    end
    for (int ang = -3216; ang <= 3216; ang += 64) begin
      run(ang, 1024, ri, rq, lat);
      chk("loop_lat", lat, 12);
      diff = $atan2(real'(rq), real'(ri)) * 1024.0 - real'(ang);
      if (diff > 3217.0) diff -= 6433.98;
      if (diff < -3217.0) diff += 6433.98;
      chk_near("loop_angle", diff, 0.0, 8.0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
